// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: CPU has fixed priority, loader has a
// starvation guard. Define ARB_LOCK_EN to add the loader exclusive-ownership (LOCKED) mode.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  input  logic                  ldr_lock,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_hold
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnLdr} owner_e;

  owner_e                rd_owner_q, rd_owner_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;
  logic                  locked;

`ifdef ARB_LOCK_EN
  typedef enum logic {StArb, StLocked} state_e;

  state_e state_q, state_d;
  logic   cpu_hold_q, cpu_hold_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:    if (ldr_lock)  state_d = StLocked;
      StLocked: if (!ldr_lock) state_d = StArb;
    endcase
    // Hold tracks the state being entered so it rises/falls with the state itself.
    cpu_hold_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StArb;
      cpu_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign locked   = (state_q == StLocked);
  assign cpu_hold = cpu_hold_q;
`else
  logic unused_ldr_lock;
  assign unused_ldr_lock = ldr_lock;
  assign locked          = 1'b0;
  assign cpu_hold        = 1'b0;
`endif

  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (locked) begin
      ldr_gnt = ldr_req;
    end else if (ldr_req && (!cpu_req || wait_cnt_q == StarveMax)) begin
      ldr_gnt = 1'b1;
    end else begin
      cpu_gnt = cpu_req;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!ldr_req || ldr_gnt || locked) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < StarveMax) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (cpu_gnt && !cpu_we) begin
      rd_owner_d = OwnCpu;
    end else if (ldr_gnt && !ldr_we) begin
      rd_owner_d = OwnLdr;
    end
    // Each side keeps its last returned word while the other side owns the read path.
    cpu_rdata_d = (rd_owner_q == OwnCpu) ? mem_rdata : cpu_rdata_q;
    ldr_rdata_d = (rd_owner_q == OwnLdr) ? mem_rdata : ldr_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner_q  <= OwnNone;
      wait_cnt_q  <= 4'd0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  assign cpu_rvalid = (rd_owner_q == OwnCpu);
  assign ldr_rvalid = (rd_owner_q == OwnLdr);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : ldr_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous RAM between two requesters: the CPU core (MAR/RAM path) and a program loader/debug port (e.g. UART loader).
- Sits between both requesters and the ram instance, and drives its we/address/data_in.
- CPU has fixed priority, with a starvation guard for the loader.
- Read data returns one cycle after grant and is tagged to the owner.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 4, RAM address width
STARVE_LIMIT, 4, consecutive denied loader cycles before the loader wins priority (1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU access request
cpu_we  input  1  CPU write (1) / read (0)
cpu_addr  input  ADDR_WIDTH  CPU address
cpu_wdata  input  DATA_WIDTH  CPU write data
cpu_gnt  output  1  CPU granted this cycle (combinational)
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  DATA_WIDTH  CPU read data
ldr_req  input  1  loader access request
ldr_we  input  1  loader write / read
ldr_addr  input  ADDR_WIDTH  loader address
ldr_wdata  input  DATA_WIDTH  loader write data
ldr_lock  input  1  loader exclusive-ownership request (see Optional Feature)
ldr_gnt  output  1  loader granted this cycle (combinational)
ldr_rvalid  output  1  loader read data valid
ldr_rdata  output  DATA_WIDTH  loader read data
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM registered read data (valid the cycle after address)
cpu_hold  output  1  registered; CPU must stall its microsequencer

Behaviour:
- Reset (async): every output 0; wait counter 0; read-owner tag NONE; FSM ARB. Any in-flight read is discarded, so no rvalid appears after reset.
- Handshake: a requester holds req/we/addr/wdata stable until it samples gnt=1 on a rising edge. A transaction is accepted on the edge where req&&gnt. At most one gnt is high per cycle.
- Grant (ARB state):
  - Only one requests → it wins.
  - Both request → CPU wins, unless wait_cnt==STARVE_LIMIT, in which case the loader wins.
- wait_cnt (4-bit):
  - Increments on each cycle with ldr_req && !ldr_gnt.
  - Saturates at STARVE_LIMIT.
  - Clears on loader grant, or when ldr_req is low.
- mem_we/mem_addr/mem_wdata: combinational mux of the winner's signals. mem_we = winner_we && gnt. With no grant: address 0, mem_we 0.
- Writes: committed at the grant edge. No response pulse.
- Reads: rd_owner register captures CPU/LDR/NONE at the grant edge. In the next cycle the owner's rvalid=1, and its rdata = mem_rdata.
  - The non-owner's rdata is held at its last value.
  - Back-to-back reads give one rvalid per cycle, each correctly tagged even when the owner alternates.
- Same-address write then read (same or different requester, consecutive cycles): the read returns the newly written value, per RAM ordering.
- Idle cycles: rvalid low, rd_owner → NONE.
- FSM: ARB, LOCKED (LOCKED is reachable only with the macro).

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined:
  - ARB with ldr_lock=1 sampled → LOCKED on the next edge. A pending CPU read still returns its rvalid normally.
  - LOCKED: cpu_gnt forced 0; cpu_hold=1 (registered, asserted in the first LOCKED cycle); the loader gets every request; wait_cnt held at 0.
  - ldr_lock=0 sampled in LOCKED → ARB next edge, cpu_hold=0 that same cycle.
  - reset mid-lock → ARB, cpu_hold=0.
- Undefined: ldr_lock ignored, cpu_hold tied 0, FSM never leaves ARB, no LOCKED logic synthesized.

Test Plan:
- Single CPU write addr 3 = 0x5A, then CPU read addr 3 → cpu_gnt both cycles; cpu_rvalid=1 with cpu_rdata=0x5A in the cycle after the read grant; ldr_rvalid stays 0.
- Both requesting continuously, STARVE_LIMIT=4 → grant pattern C,C,C,C,L repeating (loader wins every 5th cycle); wait_cnt returns to 0 after each L.
- Loader reads addr 7 (0x11) and CPU reads addr 8 (0x22) on alternating cycles → ldr_rvalid/0x11 and cpu_rvalid/0x22 appear one cycle later, never both high.
- CPU read granted, reset pulsed during the next cycle → no cpu_rvalid after reset release; all outputs 0; first request after reset is granted normally.
- ARB_LOCK_EN: ldr_lock=1 while CPU requests → cpu_hold=1 the next cycle; loader writes 0x00..0x0F to addr 0..15 at one per cycle with cpu_gnt=0 throughout; ldr_lock=0 → cpu_hold=0 and CPU is granted the next cycle.
- No macro, ldr_lock=1 with both requesting → identical to the starvation pattern C,C,C,C,L; cpu_hold stays 0.
